ipbase_intf_rr_arb: RTL and testbench

- Packet-aware round-robin arbiter that merges N_PORTS valid/ready streams onto one output stream.
- Used ahead of the NACK generator datapath, where several request sources share one downstream pipeline.
- Once a port is granted, it keeps the grant until its `last` beat, so packets are never interleaved.
- Output is registered through an internal 2-entry buffer, so every `id_rdy` is driven from flops only.

---
 rtl/ipbase_arb_pkg.sv | 41 ++++
 rtl/ipbase_intf_rr_arb_if.sv | 27 ++
 rtl/ipbase_rr_pick.sv | 25 ++
 rtl/ipbase_intf_rr_arb.sv | 158 +++++++++++++++
 tb/tb_ipbase_intf_rr_arb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipbase_arb_pkg.sv
// Shared types and the round-robin search helper for the packet-aware arbiter.
package ipbase_arb_pkg;

    // Arbiter control states: waiting for a request, or holding a grant.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Upper bound on the request vector handled by rr_pick.
    localparam int RR_MAX_PORTS = 32;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_pick_t;

    // First set bit of req searching ptr, ptr+1, ... modulo n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_PORTS-1:0] req,
                                         input int ptr,
                                         input int n);
        rr_pick_t r;
        int       j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < RR_MAX_PORTS; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!r.found && req[j]) begin
                    r.found = 1'b1;
                    r.idx   = j;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ipbase_intf_rr_arb_if.sv
// Bundle of the N request streams and the merged output stream.
// The arbiter sits on the slave side; the sources/sink drive the master side.
interface ipbase_intf_rr_arb_if #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int SRC_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
);
    logic [N_PORTS*DATA_WIDTH-1:0] id;
    logic [N_PORTS-1:0]            id_vld;
    logic [N_PORTS-1:0]            id_last;
    logic [N_PORTS-1:0]            id_rdy;
    logic [DATA_WIDTH-1:0]         od;
    logic                          od_last;
    logic [SRC_W-1:0]              od_src;
    logic                          od_vld;
    logic                          od_rdy;

    modport slave (
        input  id, id_vld, id_last, od_rdy,
        output id_rdy, od, od_last, od_src, od_vld
    );

    modport master (
        output id, id_vld, id_last, od_rdy,
        input  id_rdy, od, od_last, od_src, od_vld
    );
endinterface

// File: rtl/ipbase_rr_pick.sv
// Combinational round-robin search: first asserted request at or after ptr_i.
module ipbase_rr_pick
    import ipbase_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SRC_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic             found_o,
    output logic [SRC_W-1:0] idx_o
);
    logic [RR_MAX_PORTS-1:0] req_ext;
    rr_pick_t                pick;

    // Widen the request vector to the helper's fixed width and run the search.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
        pick           = rr_pick(req_ext, int'(ptr_i), N);
    end

    assign found_o = pick.found;
    assign idx_o   = SRC_W'(pick.idx);
endmodule

// File: rtl/ipbase_intf_rr_arb.sv
// Packet-aware round-robin arbiter: merges N_PORTS valid/ready streams into one,
// holding the grant until the packet's last beat (PKT_MODE=1) or for one beat
// (PKT_MODE=0). Output goes through a 2-entry FIFO so id_rdy depends on flops only.
module ipbase_intf_rr_arb
    import ipbase_arb_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int PKT_MODE   = 1,
    parameter int SRC_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ipbase_intf_rr_arb_if.slave  bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [SRC_W-1:0]      src;
    } entry_t;

    arb_state_e         state_q, state_d;
    logic [SRC_W-1:0]   sel_q, sel_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]   sel_inc;
    logic [1:0]         cnt_q, cnt_d;
    entry_t             head_q, head_d;
    entry_t             tail_q, tail_d;
    entry_t             in_entry;
    logic               push, pop, release_now;
    logic [N_PORTS-1:0] repick_req;
    logic               idle_found, repick_found;
    logic [SRC_W-1:0]   idle_idx, repick_idx;

    // Port after the current grant, wrapping at N_PORTS-1.
    always_comb begin
        if (sel_q == SRC_W'(N_PORTS - 1)) begin
            sel_inc = '0;
        end else begin
            sel_inc = sel_q + 1'b1;
        end
    end

    // The releasing port is masked so it gets lowest priority in the re-pick.
    assign repick_req = bus.id_vld & ~(N_PORTS'(1) << sel_q);

    ipbase_rr_pick #(.N(N_PORTS), .SRC_W(SRC_W)) u_pick_idle (
        .req_i   (bus.id_vld),
        .ptr_i   (rr_ptr_q),
        .found_o (idle_found),
        .idx_o   (idle_idx)
    );

    ipbase_rr_pick #(.N(N_PORTS), .SRC_W(SRC_W)) u_pick_repick (
        .req_i   (repick_req),
        .ptr_i   (sel_inc),
        .found_o (repick_found),
        .idx_o   (repick_idx)
    );

    // Ready only to the granted port while the buffer has room; registers only.
    always_comb begin
        bus.id_rdy = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            bus.id_rdy[i] = (state_q == LOCK) && (sel_q == SRC_W'(i)) && (cnt_q != 2'd2);
        end
    end

    // Beat capture from the granted port and grant-release detection.
    always_comb begin
        push          = (state_q == LOCK) && (cnt_q != 2'd2) && bus.id_vld[sel_q];
        pop           = (cnt_q != 2'd0) && bus.od_rdy;
        in_entry.data = bus.id[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
        in_entry.last = bus.id_last[sel_q];
        in_entry.src  = sel_q;
        release_now   = push && (bus.id_last[sel_q] || (PKT_MODE == 0));
    end

    // Grant FSM: pick in IDLE, hold in LOCK, re-pick without a bubble at release.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (idle_found) begin
                    sel_d   = idle_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (release_now) begin
                    rr_ptr_d = sel_inc;
                    if (repick_found) begin
                        sel_d = repick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry FIFO: head is always presented on od; tail holds the second beat.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = in_entry;
                end else begin
                    tail_d = in_entry;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = in_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = in_entry;
                end
            end
            default: ;
        endcase
    end

    // State and buffer registers; reset drops any held grant and buffered beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end

    assign bus.od      = head_q.data;
    assign bus.od_last = head_q.last;
    assign bus.od_src  = head_q.src;
    assign bus.od_vld  = (cnt_q != 2'd0);
endmodule

// File: tb/tb_ipbase_intf_rr_arb.sv
// Bench for ipbase_intf_rr_arb: directed scenarios plus a randomized run checked
// against a packet-level round-robin reference model.
module tb_ipbase_intf_rr_arb;
    import ipbase_arb_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          port;
        logic [15:0] data;
        logic        last;
        int          cyc;
    } ev_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    beat_t      srcq [4][$];
    ev_t        acc_log[$];
    ev_t        out_log[$];
    logic [3:0] vld_hist[$];
    logic [3:0] en;
    int         pseq [4];
    int         cyc;

    ipbase_intf_rr_arb_if #(.N_PORTS(4), .DATA_WIDTH(16)) bus_a ();
    ipbase_intf_rr_arb_if #(.N_PORTS(4), .DATA_WIDTH(16)) bus_b ();

    ipbase_intf_rr_arb #(.N_PORTS(4), .DATA_WIDTH(16), .PKT_MODE(1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    ipbase_intf_rr_arb #(.N_PORTS(4), .DATA_WIDTH(16), .PKT_MODE(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mkdata(int p, int s);
        return 16'h8000 | 16'(p << 8) | 16'(s & 255);
    endfunction

    // Round-robin rule: first requesting port at ptr, ptr+1, ... mod 4.
    function automatic int rr_first(logic [3:0] v, int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic add_pkt(int p, int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = mkdata(p, pseq[p]);
            b.last = (i == len - 1);
            srcq[p].push_back(b);
            pseq[p]++;
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < 4; p++) begin
            srcq[p].delete();
            pseq[p] = 0;
        end
        acc_log.delete();
        out_log.delete();
        vld_hist.delete();
        en  = '0;
        cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.id = '0; bus_a.id_vld = '0; bus_a.id_last = '0; bus_a.od_rdy = 1'b0;
        bus_b.id = '0; bus_b.id_vld = '0; bus_b.id_last = '0; bus_b.od_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    // One clock of the source/sink drivers for dut_a; logs every handshake.
    task automatic cycle_a();
        logic [3:0]  v, r, l;
        logic [63:0] d;
        ev_t         e;
        v = '0; l = '0; d = '0;
        for (int p = 0; p < 4; p++) begin
            if (en[p] && srcq[p].size() > 0) begin
                v[p] = 1'b1;
                d[p*16 +: 16] = srcq[p][0].data;
                l[p] = srcq[p][0].last;
            end
        end
        bus_a.id = d; bus_a.id_last = l; bus_a.id_vld = v;
        r = bus_a.id_rdy;
        vld_hist.push_back(v);
        for (int p = 0; p < 4; p++) begin
            if (!rst && v[p] && r[p]) begin
                e.port = p; e.data = srcq[p][0].data; e.last = srcq[p][0].last; e.cyc = cyc;
                acc_log.push_back(e);
            end
        end
        if (!rst && bus_a.od_vld && bus_a.od_rdy) begin
            e.port = int'(bus_a.od_src); e.data = bus_a.od; e.last = bus_a.od_last; e.cyc = cyc;
            out_log.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (!rst && v[p] && r[p]) void'(srcq[p].pop_front());
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.id_vld = 4'hF; bus_a.id_last = 4'hF; bus_a.od_rdy = 1'b1;
        bus_b.id_vld = 4'hF; bus_b.id_last = 4'hF; bus_b.od_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.od_vld !== 1'b0) begin errors++; $display("FAIL reset_od_vld got %b want 0", bus_a.od_vld); end
        checks++; if (bus_a.id_rdy !== 4'b0) begin errors++; $display("FAIL reset_id_rdy got %b want 0000", bus_a.id_rdy); end
        checks++; if (bus_a.od !== 16'h0 || bus_a.od_last !== 1'b0 || bus_a.od_src !== 2'd0) begin errors++; $display("FAIL reset_od got %h/%b/%0d want 0/0/0", bus_a.od, bus_a.od_last, bus_a.od_src); end
        checks++; if (dut_a.state_q !== IDLE || dut_a.rr_ptr_q !== 2'd0 || dut_a.cnt_q !== 2'd0) begin errors++; $display("FAIL reset_state got %0d/%0d/%0d want IDLE/0/0", dut_a.state_q, dut_a.rr_ptr_q, dut_a.cnt_q); end
        checks++; if (bus_b.od_vld !== 1'b0 || bus_b.id_rdy !== 4'b0) begin errors++; $display("FAIL reset_b got %b/%b want 0/0000", bus_b.od_vld, bus_b.id_rdy); end
        do_reset();
    endtask

    task automatic test_single_port();
        do_reset();
        bus_a.od_rdy = 1'b1;
        add_pkt(2, 3);
        en = 4'b0100;
        checks++; if (bus_a.id_rdy !== 4'b0) begin errors++; $display("FAIL single_idle_rdy got %b want 0000", bus_a.id_rdy); end
        repeat (7) cycle_a();
        checks++; if (out_log.size() != 3) begin errors++; $display("FAIL single_count got %0d want 3", out_log.size()); end
        for (int k = 0; k < out_log.size() && k < 3; k++) begin
            checks++;
            if (out_log[k].data !== mkdata(2, k) || out_log[k].port != 2 || out_log[k].last !== (k == 2) || out_log[k].cyc != k + 2) begin
                errors++;
                $display("FAIL single_beat%0d got d=%h src=%0d last=%b cyc=%0d want d=%h src=2 last=%b cyc=%0d",
                         k, out_log[k].data, out_log[k].port, out_log[k].last, out_log[k].cyc, mkdata(2, k), k == 2, k + 2);
            end
        end
        checks++; if (dut_a.state_q !== IDLE || dut_a.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL single_final got state=%0d ptr=%0d want IDLE/3", dut_a.state_q, dut_a.rr_ptr_q); end
    endtask

    task automatic test_all_ports();
        int n;
        do_reset();
        bus_a.od_rdy = 1'b1;
        for (int p = 0; p < 4; p++) begin add_pkt(p, 2); add_pkt(p, 2); end
        en = 4'hF;
        n = 0;
        while (out_log.size() < 10 && n < 60) begin cycle_a(); n++; end
        checks++; if (out_log.size() < 10) begin errors++; $display("FAIL all_ports_count got %0d want 10", out_log.size()); end
        for (int k = 0; k < out_log.size() && k < 10; k++) begin
            checks++;
            if (out_log[k].port != (k / 2) % 4 || out_log[k].data !== mkdata((k / 2) % 4, (k / 8) * 2 + k % 2)
                || out_log[k].last !== (k % 2 == 1) || out_log[k].cyc != out_log[0].cyc + k) begin
                errors++;
                $display("FAIL all_ports_beat%0d got src=%0d d=%h last=%b cyc=%0d want src=%0d d=%h last=%b cyc=%0d",
                         k, out_log[k].port, out_log[k].data, out_log[k].last, out_log[k].cyc,
                         (k / 2) % 4, mkdata((k / 2) % 4, (k / 8) * 2 + k % 2), k % 2 == 1, out_log[0].cyc + k);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        bus_a.od_rdy = 1'b0;
        add_pkt(0, 8);
        en = 4'b0001;
        n = 0;
        while (!bus_a.od_vld && n < 10) begin cycle_a(); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus_a.od_vld !== 1'b1 || bus_a.od !== mkdata(0, 0) || bus_a.od_src !== 2'd0) begin errors++; $display("FAIL stall_hold%0d got vld=%b d=%h want 1/%h", i, bus_a.od_vld, bus_a.od, mkdata(0, 0)); end
            if (i >= 1) begin
                checks++; if (bus_a.id_rdy !== 4'b0) begin errors++; $display("FAIL stall_rdy%0d got %b want 0000", i, bus_a.id_rdy); end
            end
            cycle_a();
        end
        checks++; if (acc_log.size() != 2 || out_log.size() != 0) begin errors++; $display("FAIL stall_buffered got acc=%0d out=%0d want 2/0", acc_log.size(), out_log.size()); end
        bus_a.od_rdy = 1'b1;
        n = 0;
        while (out_log.size() < 8 && n < 40) begin cycle_a(); n++; end
        checks++; if (out_log.size() != 8) begin errors++; $display("FAIL stall_drain_count got %0d want 8", out_log.size()); end
        for (int k = 0; k < out_log.size() && k < 8; k++) begin
            checks++; if (out_log[k].data !== mkdata(0, k) || out_log[k].last !== (k == 7)) begin errors++; $display("FAIL stall_drain%0d got %h/%b want %h/%b", k, out_log[k].data, out_log[k].last, mkdata(0, k), k == 7); end
        end
    endtask

    task automatic test_grant_hold();
        int n;
        do_reset();
        bus_a.od_rdy = 1'b1;
        add_pkt(1, 4);
        add_pkt(3, 2);
        en = 4'b1010;
        n = 0;
        while (acc_log.size() < 2 && n < 20) begin cycle_a(); n++; end
        en = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus_a.id_rdy !== 4'b0010) begin errors++; $display("FAIL hold_rdy%0d got %b want 0010", i, bus_a.id_rdy); end
            cycle_a();
        end
        checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL hold_accepted got %0d want 2", acc_log.size()); end
        en = 4'b1010;
        n = 0;
        while (out_log.size() < 6 && n < 40) begin cycle_a(); n++; end
        checks++; if (out_log.size() != 6) begin errors++; $display("FAIL hold_count got %0d want 6", out_log.size()); end
        for (int k = 0; k < out_log.size() && k < 6; k++) begin
            checks++; if (out_log[k].port != ((k < 4) ? 1 : 3)) begin errors++; $display("FAIL hold_src%0d got %0d want %0d", k, out_log[k].port, (k < 4) ? 1 : 3); end
        end
    endtask

    task automatic test_beat_mode();
        int         bseq [2];
        logic [3:0] r;
        ev_t        e;
        ev_t        outb[$];
        do_reset();
        bseq[0] = 0; bseq[1] = 0;
        bus_b.od_rdy = 1'b1;
        bus_b.id_vld = 4'b0011;
        bus_b.id_last = 4'b0000;
        for (int c = 0; c < 14; c++) begin
            bus_b.id[15:0]  = mkdata(0, bseq[0]);
            bus_b.id[31:16] = mkdata(1, bseq[1]);
            r = bus_b.id_rdy;
            if (bus_b.od_vld) begin
                e.port = int'(bus_b.od_src); e.data = bus_b.od; e.last = bus_b.od_last; e.cyc = c;
                outb.push_back(e);
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) if (r[p]) bseq[p]++;
        end
        bus_b.id_vld = 4'b0000;
        checks++; if (outb.size() < 8) begin errors++; $display("FAIL beat_count got %0d want >=8", outb.size()); end
        for (int k = 0; k < outb.size() && k < 8; k++) begin
            checks++;
            if (outb[k].port != k % 2 || outb[k].data !== mkdata(k % 2, k / 2) || outb[k].cyc != k + 2) begin
                errors++;
                $display("FAIL beat_alt%0d got src=%0d d=%h cyc=%0d want src=%0d d=%h cyc=%0d",
                         k, outb[k].port, outb[k].data, outb[k].cyc, k % 2, mkdata(k % 2, k / 2), k + 2);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        int n;
        do_reset();
        bus_a.od_rdy = 1'b0;
        add_pkt(0, 6);
        en = 4'b0001;
        n = 0;
        while (!(bus_a.od_vld && bus_a.id_rdy == 4'b0) && n < 10) begin cycle_a(); n++; end
        checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL rstmid_buffered got %0d want 2", acc_log.size()); end
        en = '0;
        rst = 1'b1;
        cycle_a();
        checks++; if (bus_a.od_vld !== 1'b0 || bus_a.id_rdy !== 4'b0) begin errors++; $display("FAIL rstmid_outputs got vld=%b rdy=%b want 0/0000", bus_a.od_vld, bus_a.id_rdy); end
        checks++; if (dut_a.state_q !== IDLE || dut_a.rr_ptr_q !== 2'd0 || dut_a.cnt_q !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d/%0d/%0d want IDLE/0/0", dut_a.state_q, dut_a.rr_ptr_q, dut_a.cnt_q); end
        rst = 1'b0;
        clear_model();
        add_pkt(0, 3);
        en = 4'b0001;
        bus_a.od_rdy = 1'b1;
        repeat (7) cycle_a();
        checks++; if (out_log.size() != 3) begin errors++; $display("FAIL rstmid_count got %0d want 3", out_log.size()); end
        for (int k = 0; k < out_log.size() && k < 3; k++) begin
            checks++;
            if (out_log[k].data !== mkdata(0, k) || out_log[k].port != 0 || out_log[k].last !== (k == 2) || out_log[k].cyc != k + 2) begin
                errors++;
                $display("FAIL rstmid_beat%0d got d=%h src=%0d last=%b cyc=%0d want d=%h src=0 last=%b cyc=%0d",
                         k, out_log[k].data, out_log[k].port, out_log[k].last, out_log[k].cyc, mkdata(0, k), k == 2, k + 2);
            end
        end
    endtask

    task automatic test_random();
        int          total, n, ptr, grant, start, c, expg;
        logic [3:0]  m;
        logic        prev_stall;
        logic [15:0] prev_od;
        logic [1:0]  prev_src;
        logic        prev_last;
        do_reset();
        total = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 12; i++) begin
                n = $urandom_range(1, 4);
                add_pkt(p, n);
                total += n;
            end
        end
        prev_stall = 1'b0; prev_od = '0; prev_src = '0; prev_last = 1'b0;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 4; p++) en[p] = ($urandom_range(0, 99) < 60);
            bus_a.od_rdy = ($urandom_range(0, 99) < 70);
            if (prev_stall) begin
                checks++;
                if (bus_a.od_vld !== 1'b1 || bus_a.od !== prev_od || bus_a.od_src !== prev_src || bus_a.od_last !== prev_last) begin
                    errors++;
                    $display("FAIL rand_stall_stable cyc=%0d got vld=%b d=%h want 1/%h", cyc, bus_a.od_vld, bus_a.od, prev_od);
                end
            end
            prev_stall = bus_a.od_vld && !bus_a.od_rdy;
            prev_od = bus_a.od; prev_src = bus_a.od_src; prev_last = bus_a.od_last;
            cycle_a();
        end
        en = 4'hF;
        bus_a.od_rdy = 1'b1;
        n = 0;
        while (!(srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 && srcq[3].size() == 0
                 && out_log.size() == acc_log.size()) && n < 1000) begin
            cycle_a();
            n++;
        end
        checks++; if (acc_log.size() != total || out_log.size() != total) begin errors++; $display("FAIL rand_totals got acc=%0d out=%0d want %0d", acc_log.size(), out_log.size(), total); end
        for (int k = 0; k < out_log.size() && k < acc_log.size(); k++) begin
            checks++;
            if (out_log[k].data !== acc_log[k].data || out_log[k].port != acc_log[k].port || out_log[k].last !== acc_log[k].last) begin
                errors++;
                $display("FAIL rand_order%0d got d=%h src=%0d want d=%h src=%0d", k, out_log[k].data, out_log[k].port, acc_log[k].data, acc_log[k].port);
            end
        end
        // Packet-level round-robin reference: who must own each accepted beat.
        ptr = 0; grant = -1; start = 0;
        foreach (acc_log[i]) begin
            if (grant < 0) begin
                c = start;
                while (c < vld_hist.size() && vld_hist[c] == 4'b0) c++;
                expg = (c < vld_hist.size()) ? rr_first(vld_hist[c], ptr) : -1;
            end else begin
                expg = grant;
            end
            checks++;
            if (acc_log[i].port != expg) begin
                errors++;
                $display("FAIL rand_grant beat%0d cyc=%0d got port=%0d want %0d", i, acc_log[i].cyc, acc_log[i].port, expg);
            end
            grant = acc_log[i].port;
            if (acc_log[i].last) begin
                ptr = (grant + 1) % 4;
                m = vld_hist[acc_log[i].cyc] & ~(4'b0001 << grant);
                if (m != 4'b0) begin
                    grant = rr_first(m, ptr);
                end else begin
                    grant = -1;
                    start = acc_log[i].cyc + 1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_model();
        test_reset();
        test_single_port();
        test_all_ports();
        test_backpressure();
        test_grant_hold();
        test_beat_mode();
        test_reset_midpacket();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
